// File: rtl/instr_step_sequencer.sv
// Per-instruction step sequencer: fetch/decode/memory/execute/advance with one pc_inc per retired instruction.
// Optional INSTR_STEP_TIMEOUT_EN adds a mem_ack wait limit and a mem_err pulse.
module instr_step_sequencer #(
  parameter int unsigned          OP_W        = 4,
  parameter logic [OP_W-1:0]      OP_LDR      = 4'h1,
  parameter logic [OP_W-1:0]      OP_STR      = 4'h2,
  parameter logic [OP_W-1:0]      OP_ADD      = 4'h3,
  parameter int unsigned          CNT_W       = 8,
  parameter int unsigned          MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [OP_W-1:0]  opcode,
  output logic             instr_ready,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             sel_ldr,
  output logic             sel_str,
  output logic             sel_add,
  output logic             pc_inc,
  output logic             busy,
  output logic [CNT_W-1:0] retired_cnt
`ifdef INSTR_STEP_TIMEOUT_EN
  ,
  output logic             mem_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_MEM,
    S_EXEC,
    S_ADVANCE
  } state_t;

  state_t          state, next_state;
  logic [OP_W-1:0] op_q;
  logic            accept;
  logic            timeout_hit;

`ifdef INSTR_STEP_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt;
`endif

  // instr_ready is the registered view of IDLE, so an opcode is only taken once it is visible
  assign accept = (state == S_IDLE) && instr_ready && instr_valid;

  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
`ifdef INSTR_STEP_TIMEOUT_EN
    timeout_hit = (state == S_MEM) && !mem_ack && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
`endif
    case (state)
      S_IDLE:    if (accept) next_state = S_DECODE;
      S_DECODE: begin
        if (op_q == OP_LDR || op_q == OP_STR) next_state = S_MEM;
        else if (op_q == OP_ADD)              next_state = S_EXEC;
        else                                  next_state = S_ADVANCE;
      end
      S_MEM:     if (mem_ack || timeout_hit) next_state = S_ADVANCE;
      S_EXEC:    next_state = S_ADVANCE;
      S_ADVANCE: next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      op_q        <= '0;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      sel_ldr     <= 1'b0;
      sel_str     <= 1'b0;
      sel_add     <= 1'b0;
      pc_inc      <= 1'b0;
      retired_cnt <= '0;
    end else begin
      state       <= next_state;
      if (accept) op_q <= opcode;
      instr_ready <= (state == S_IDLE) && !accept;
      busy        <= (state != S_IDLE) || accept;
      mem_req     <= (next_state == S_MEM);
      mem_we      <= (next_state == S_MEM) && (op_q == OP_STR);
      pc_inc      <= (state == S_ADVANCE);
      if (state == S_ADVANCE) retired_cnt <= retired_cnt + 1'b1;
      // selects are loaded in DECODE and held until the sequencer is back in IDLE
      if (state == S_DECODE) begin
        sel_ldr <= (op_q == OP_LDR);
        sel_str <= (op_q == OP_STR);
        sel_add <= (op_q == OP_ADD);
      end else if (state == S_IDLE) begin
        sel_ldr <= 1'b0;
        sel_str <= 1'b0;
        sel_add <= 1'b0;
      end
    end
  end

`ifdef INSTR_STEP_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      wait_cnt <= (state == S_MEM) ? wait_cnt + 1'b1 : '0;
      mem_err  <= timeout_hit;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = timeout_hit;
`endif

endmodule

// File: tb/tb_instr_step_sequencer.sv
// Directed bench for instr_step_sequencer: table of single instructions plus hand-written corner sequences.
module tb_instr_step_sequencer;
  localparam logic [3:0] OP_LDR = 4'h1;
  localparam logic [3:0] OP_STR = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam int NWIN = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic [3:0] opcode;
  logic       instr_ready;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_we;
  logic       sel_ldr;
  logic       sel_str;
  logic       sel_add;
  logic       pc_inc;
  logic       busy;
  logic [7:0] retired_cnt;
`ifdef INSTR_STEP_TIMEOUT_EN
  logic       mem_err;
`endif

  instr_step_sequencer #(
    .OP_W(4), .OP_LDR(OP_LDR), .OP_STR(OP_STR), .OP_ADD(OP_ADD),
    .CNT_W(8), .MEM_TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
    .instr_ready(instr_ready), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .sel_ldr(sel_ldr), .sel_str(sel_str), .sel_add(sel_add), .pc_inc(pc_inc),
    .busy(busy), .retired_cnt(retired_cnt)
`ifdef INSTR_STEP_TIMEOUT_EN
    , .mem_err(mem_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int o_pc  [NWIN];
  int o_req [NWIN];
  int o_we  [NWIN];
  int o_rdy [NWIN];
  int o_busy[NWIN];
  int o_sel [NWIN];
  int o_err [NWIN];
  int cnt0, cnt_end;

  typedef struct {
    logic [3:0] op;
    int         ack_k;   // ack cycles after mem_req rises, -1 = none
    int         pc_cyc;
    int         sel;     // {ldr,str,add}
    int         req_n;
    int         we;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; instr_valid = 1'b0; mem_ack = 1'b0; opcode = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // accept cycle is cycle 0; outputs of cycle n are sampled at its falling edge
  task automatic run_one(input logic [3:0] op, input int ack_cyc, input int ncyc);
    int w;
    w = 0;
    @(negedge clk);
    while (!instr_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!instr_ready) begin
      checks++; errors++;
      $display("FAIL ready_wait: got 0 expected 1");
    end
    cnt0 = retired_cnt;
    instr_valid = 1'b1;
    opcode = op;
    for (int n = 0; n < NWIN; n++) begin
      o_pc[n] = 0; o_req[n] = 0; o_we[n] = 0; o_rdy[n] = 0; o_busy[n] = 0; o_sel[n] = 0; o_err[n] = 0;
    end
    for (int n = 1; n < ncyc; n++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      o_pc[n]   = pc_inc;
      o_req[n]  = mem_req;
      o_we[n]   = mem_we;
      o_rdy[n]  = instr_ready;
      o_busy[n] = busy;
      o_sel[n]  = {sel_ldr, sel_str, sel_add};
`ifdef INSTR_STEP_TIMEOUT_EN
      o_err[n]  = mem_err;
`endif
      mem_ack = (n == ack_cyc);
    end
    mem_ack = 1'b0;
    cnt_end = retired_cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_pc, pc_n, req_n, we_n, first_req, sel_bad, multi;
    int pulses, prev_pc, consec, we_bad, gap_bad, last_pc_cyc, cnt255, cnt256, cyc;
    string tag;

    vecs[0] = '{4'h0,   -1, 3, 3'b000, 0, 0};
    vecs[1] = '{OP_ADD, -1, 4, 3'b001, 0, 0};
    vecs[2] = '{OP_LDR,  0, 4, 3'b100, 1, 0};
    vecs[3] = '{OP_LDR,  3, 7, 3'b100, 4, 0};
    vecs[4] = '{OP_STR,  1, 5, 3'b010, 2, 1};
    vecs[5] = '{4'hF,   -1, 3, 3'b000, 0, 0};
    vecs[6] = '{OP_STR,  0, 4, 3'b010, 1, 1};

    reset = 1'b1; instr_valid = 1'b0; mem_ack = 1'b0; opcode = '0;
    do_reset();

    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", retired_cnt, 0);
    chk("rst_outs", {pc_inc, mem_req, mem_we, sel_ldr, sel_str, sel_add}, 0);

    // stray ack while idle must be ignored
    mem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_ack_outs", {pc_inc, mem_req, busy, sel_ldr}, 0);
    end
    mem_ack = 1'b0;
    chk("stray_ack_cnt", retired_cnt, 0);

    for (int i = 0; i < 7; i++) begin
      run_one(vecs[i].op, (vecs[i].ack_k < 0) ? -1 : 2 + vecs[i].ack_k, 20);
      first_pc = -1; pc_n = 0; req_n = 0; we_n = 0; first_req = -1; sel_bad = 0; multi = 0;
      for (int n = 1; n < 20; n++) begin
        if (o_pc[n] != 0) begin pc_n++; if (first_pc < 0) first_pc = n; end
        if (o_req[n] != 0) begin req_n++; if (first_req < 0) first_req = n; end
        if (o_we[n] != 0) we_n++;
        if ($countones(o_sel[n][2:0]) > 1) multi++;
        if (n >= 2 && n <= vecs[i].pc_cyc && o_sel[n] != vecs[i].sel) sel_bad++;
      end
      tag = $sformatf("v%0d_", i);
      chk({tag, "busy_c1"}, o_busy[1], 1);
      chk({tag, "ready_c1"}, o_rdy[1], 0);
      chk({tag, "pc_first"}, first_pc, vecs[i].pc_cyc);
      chk({tag, "pc_count"}, pc_n, 1);
      chk({tag, "sel_c2"}, o_sel[2], vecs[i].sel);
      chk({tag, "sel_held"}, sel_bad, 0);
      chk({tag, "sel_clear"}, o_sel[vecs[i].pc_cyc + 1], 0);
      chk({tag, "sel_onehot"}, multi, 0);
      chk({tag, "req_cycles"}, req_n, vecs[i].req_n);
      chk({tag, "we_cycles"}, we_n, vecs[i].we * vecs[i].req_n);
      if (vecs[i].req_n > 0) chk({tag, "req_rise"}, first_req, 2);
      chk({tag, "ready_at_pc"}, o_rdy[vecs[i].pc_cyc], 0);
      chk({tag, "ready_ret"}, o_rdy[vecs[i].pc_cyc + 1], 1);
      chk({tag, "retired"}, (cnt_end - cnt0 + 256) % 256, 1);
    end

    // back-to-back STR with ack tied high, 256 instructions to wrap the counter
    do_reset();
    opcode = OP_STR; instr_valid = 1'b1; mem_ack = 1'b1;
    pulses = 0; prev_pc = 0; consec = 0; we_bad = 0; gap_bad = 0;
    last_pc_cyc = -1; cnt255 = -1; cnt256 = -1; cyc = 0;
    while (pulses < 256 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (pc_inc && prev_pc) consec++;
      if (mem_req != mem_we) we_bad++;
      if (pc_inc) begin
        pulses++;
        if (last_pc_cyc >= 0 && cyc - last_pc_cyc != 5) gap_bad++;
        last_pc_cyc = cyc;
        if (pulses == 255) cnt255 = retired_cnt;
        if (pulses == 256) begin
          cnt256 = retired_cnt;
          instr_valid = 1'b0;
        end
      end
      prev_pc = pc_inc;
    end
    instr_valid = 1'b0; mem_ack = 1'b0;
    chk("b2b_pulses", pulses, 256);
    chk("b2b_consec_pc", consec, 0);
    chk("b2b_we_with_req", we_bad, 0);
    chk("b2b_gap", gap_bad, 0);
    chk("b2b_cnt255", cnt255, 255);
    chk("b2b_wrap", cnt256, 0);
    repeat (8) @(negedge clk);
    chk("b2b_quiet_cnt", retired_cnt, 0);
    chk("b2b_quiet_ready", instr_ready, 1);

    // reset while waiting in MEM
    run_one(OP_ADD, -1, 8);
    chk("pre_rst_cnt", retired_cnt, 1);
    @(negedge clk);
    instr_valid = 1'b1; opcode = OP_LDR;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      instr_valid = 1'b0;
    end
    chk("mem_wait_req", mem_req, 1);
    chk("mem_wait_sel", sel_ldr, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_req", mem_req, 0);
    chk("abort_sel", sel_ldr, 0);
    chk("abort_pc", pc_inc, 0);
    chk("abort_cnt", retired_cnt, 0);
    chk("abort_idle", {instr_ready, busy}, 2'b10);
    pc_n = 0;
    repeat (10) begin
      @(negedge clk);
      if (pc_inc) pc_n++;
    end
    chk("abort_no_pc", pc_n, 0);

`ifdef INSTR_STEP_TIMEOUT_EN
    // no ack: 15 MEM cycles, mem_err, then retire; ack two cycles after mem_err is ignored
    run_one(OP_LDR, 19, 26);
    first_pc = -1; pc_n = 0; req_n = 0; first_req = -1; we_n = 0;
    for (int n = 1; n < 26; n++) begin
      if (o_pc[n] != 0) begin pc_n++; if (first_pc < 0) first_pc = n; end
      if (o_req[n] != 0) req_n++;
      if (o_err[n] != 0) begin we_n++; if (first_req < 0) first_req = n; end
    end
    chk("to_req_cycles", req_n, 15);
    chk("to_err_cycle", first_req, 17);
    chk("to_err_count", we_n, 1);
    chk("to_pc_cycle", first_pc, 18);
    chk("to_pc_count", pc_n, 1);
    chk("to_retired", (cnt_end - cnt0 + 256) % 256, 1);
    chk("to_late_ack_ready", o_rdy[25], 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
